// File: rtl/red_pitaya_dna_ctrl.sv
// DNA_PORT readout sequencer: loads the 57-bit device DNA, shifts it out bit-serially
// and publishes it atomically with busy/done status.
module red_pitaya_dna_ctrl #(
  parameter int CLK_DIV    = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [56:0] dna_value_o,
  output logic        dna_clk_o,
  output logic        dna_read_o,
  output logic        dna_shift_o,
  input  logic        dna_dout_i
);

  generate
    if (CLK_DIV < 2 || CLK_DIV > 64) begin : g_bad_div
      $error("red_pitaya_dna_ctrl: CLK_DIV must be within 2..64");
    end
  endgenerate

  localparam int             PH_W    = $clog2(2 * CLK_DIV);
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [5:0]      BIT_LAST = 6'd56;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t          state;
  logic [PH_W-1:0] ph;
  logic [5:0]      bit_cnt;
  logic [56:0]     sr;
  logic            auto_pend;

  // auto_pend starts a readout in the first cycle after reset release
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      ph          <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      auto_pend   <= AUTO_START;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      dna_value_o <= '0;
      dna_clk_o   <= 1'b0;
      dna_read_o  <= 1'b0;
      dna_shift_o <= 1'b0;
    end else begin
      auto_pend <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i || auto_pend) begin
            state       <= LOAD;
            busy_o      <= 1'b1;
            done_o      <= 1'b0;
            dna_read_o  <= 1'b1;
            dna_shift_o <= 1'b0;
            dna_clk_o   <= 1'b0;
            ph          <= '0;
            bit_cnt     <= '0;
          end
        end

        LOAD: begin
          ph <= ph + 1'b1;
          if (ph == PH_MID) dna_clk_o <= 1'b1;
          if (ph == PH_LAST) begin
            ph          <= '0;
            dna_clk_o   <= 1'b0;
            state       <= SHIFT;
            dna_read_o  <= 1'b0;
            dna_shift_o <= 1'b1;
            bit_cnt     <= '0;
          end
        end

        SHIFT: begin
          ph <= ph + 1'b1;
          // sample DOUT in the last low cycle, right before the shifting edge
          if (ph == PH_MID) begin
            dna_clk_o <= 1'b1;
            sr        <= {sr[55:0], dna_dout_i};
          end
          if (ph == PH_LAST) begin
            ph        <= '0;
            dna_clk_o <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state       <= IDLE;
              busy_o      <= 1'b0;
              done_o      <= 1'b1;
              dna_value_o <= sr;
              dna_shift_o <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_red_pitaya_dna_ctrl.sv
// Directed bench for red_pitaya_dna_ctrl: three instances (auto D=4, manual D=4, auto D=2)
// each driving a behavioural DNA_PORT model.
module tb_red_pitaya_dna_ctrl;

  localparam logic [56:0] V0 = 57'h0823456789ABCDE;
  localparam logic [56:0] V1 = 57'h1FFFFFFFFFFFFFF;

  logic        clk = 1'b0;
  logic        rstn  [3];
  logic        start [3];
  logic [56:0] mval  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_u
    logic        busy, done, dclk, dread, dshift, ddout;
    logic [56:0] value;
    logic [56:0] mreg;
    int          edges = 0, read_edges = 0, shift_edges = 0, ctrl_bad = 0;
    logic [1:0]  prev_ctrl = 2'b00;

    red_pitaya_dna_ctrl #(
      .CLK_DIV   ((gi == 2) ? 2 : 4),
      .AUTO_START(gi != 1)
    ) u_dut (
      .clk_i      (clk),
      .rstn_i     (rstn[gi]),
      .start_i    (start[gi]),
      .busy_o     (busy),
      .done_o     (done),
      .dna_value_o(value),
      .dna_clk_o  (dclk),
      .dna_read_o (dread),
      .dna_shift_o(dshift),
      .dna_dout_i (ddout)
    );

    // DNA_PORT model: READ loads, SHIFT shifts toward the MSB, DOUT is the MSB
    always @(posedge dclk) begin
      edges++;
      if (dread) read_edges++;
      if (dshift) shift_edges++;
      if (dread) mreg <= mval[gi];
      else if (dshift) mreg <= {mreg[55:0], 1'b0};
    end
    assign ddout = mreg[56];

    always @(negedge clk) begin
      if (({dread, dshift} != prev_ctrl) && dclk) ctrl_bad++;
      prev_ctrl = {dread, dshift};
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int e0, r0, s0, busy_low, busy_seen;
    for (int i = 0; i < 3; i++) begin
      rstn[i]  = 1'b0;
      start[i] = 1'b0;
      mval[i]  = V0;
    end
    tick(3);

    // Power-up auto readout, D=4
    check("rst_ctrl", {59'd0, g_u[0].busy, g_u[0].done, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'd0);
    check("rst_value", {7'd0, g_u[0].value}, 64'd0);
    e0 = g_u[0].edges; r0 = g_u[0].read_edges; s0 = g_u[0].shift_edges;
    rstn[0] = 1'b1;
    for (int c = 1; c <= 465; c++) begin
      tick(1);
      if (c == 1) check("pu_c1", {59'd0, g_u[0].busy, g_u[0].done, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'b10010);
      if (c == 4) check("pu_clk_c4", {63'd0, g_u[0].dclk}, 64'd0);
      if (c == 5) check("pu_clk_c5", {63'd0, g_u[0].dclk}, 64'd1);
      if (c == 8) check("pu_c8", {61'd0, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'b110);
      if (c == 9) check("pu_c9", {61'd0, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'b001);
      if (c == 464) check("pu_c464", {62'd0, g_u[0].busy, g_u[0].done}, 64'b10);
      if (c == 464) check("pu_val464", {7'd0, g_u[0].value}, 64'd0);
    end
    check("pu_c465", {59'd0, g_u[0].busy, g_u[0].done, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'b01000);
    check("pu_value", {7'd0, g_u[0].value}, {7'd0, V0});
    check("pu_edges", 64'(g_u[0].edges - e0), 64'd58);
    check("pu_read_edges", 64'(g_u[0].read_edges - r0), 64'd1);
    check("pu_shift_edges", 64'(g_u[0].shift_edges - s0), 64'd57);

    // Re-read with a new model value: old value must stay until completion
    tick(5);
    mval[0] = V1;
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    check("rr_c1", {62'd0, g_u[0].busy, g_u[0].done}, 64'b10);
    check("rr_val1", {7'd0, g_u[0].value}, {7'd0, V0});
    for (int c = 2; c <= 465; c++) begin
      tick(1);
      if (c == 200) check("rr_val200", {7'd0, g_u[0].value}, {7'd0, V0});
      if (c == 464) check("rr_val464", {7'd0, g_u[0].value}, {7'd0, V0});
    end
    check("rr_done", {62'd0, g_u[0].busy, g_u[0].done}, 64'b01);
    check("rr_value", {7'd0, g_u[0].value}, {7'd0, V1});

    // Async reset in the middle of the shift phase
    start[0] = 1'b1;
    tick(1);
    start[0] = 1'b0;
    tick(199);
    rstn[0] = 1'b0;
    #1;
    check("mr_ctrl", {59'd0, g_u[0].busy, g_u[0].done, g_u[0].dclk, g_u[0].dread, g_u[0].dshift}, 64'd0);
    check("mr_value", {7'd0, g_u[0].value}, 64'd0);
    tick(2);
    rstn[0] = 1'b1;
    tick(464);
    check("mr_c464", {62'd0, g_u[0].busy, g_u[0].done}, 64'b10);
    tick(1);
    check("mr_c465", {62'd0, g_u[0].busy, g_u[0].done}, 64'b01);
    check("mr_value_after", {7'd0, g_u[0].value}, {7'd0, V1});

    // Manual start instance stays quiet without a request
    e0 = g_u[1].edges;
    rstn[1] = 1'b1;
    busy_seen = 0;
    for (int c = 0; c < 1000; c++) begin
      tick(1);
      if (g_u[1].busy) busy_seen++;
    end
    check("man_idle_busy", 64'(busy_seen), 64'd0);
    check("man_idle_edges", 64'(g_u[1].edges - e0), 64'd0);

    // Manual start with ignored requests at cycles 50 and 300
    start[1] = 1'b1;
    tick(1);
    start[1] = 1'b0;
    busy_low = 0;
    for (int c = 1; c <= 465; c++) begin
      if (c > 1 && c <= 464 && !g_u[1].busy) busy_low++;
      if (c == 464) check("man_c464", {62'd0, g_u[1].busy, g_u[1].done}, 64'b10);
      tick(1);
      if (c == 50 || c == 300) start[1] = 1'b1;
      if (c == 51 || c == 301) start[1] = 1'b0;
    end
    check("man_c465", {62'd0, g_u[1].busy, g_u[1].done}, 64'b01);
    check("man_value", {7'd0, g_u[1].value}, {7'd0, V0});
    check("man_busy_gap", 64'(busy_low), 64'd0);
    busy_seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick(1);
      if (g_u[1].busy) busy_seen++;
    end
    check("man_no_requeue", 64'(busy_seen), 64'd0);
    check("man_edges", 64'(g_u[1].edges - e0), 64'd58);

    // D=2 instance: 4-cycle DNA clock period, done at 233
    rstn[2] = 1'b1;
    for (int c = 1; c <= 233; c++) begin
      tick(1);
      if (c <= 8) begin
        check($sformatf("d2_clk_c%0d", c), {63'd0, g_u[2].dclk}, (((c - 1) % 4) >= 2) ? 64'd1 : 64'd0);
        check($sformatf("d2_rs_c%0d", c), {62'd0, g_u[2].dread, g_u[2].dshift}, (c <= 4) ? 64'b10 : 64'b01);
      end
      if (c == 232) check("d2_c232", {62'd0, g_u[2].busy, g_u[2].done}, 64'b10);
    end
    check("d2_c233", {62'd0, g_u[2].busy, g_u[2].done}, 64'b01);
    check("d2_value", {7'd0, g_u[2].value}, {7'd0, V0});
    check("d2_edges", 64'(g_u[2].edges), 64'd58);

    check("ctrl_setup_u0", 64'(g_u[0].ctrl_bad), 64'd0);
    check("ctrl_setup_u1", 64'(g_u[1].ctrl_bad), 64'd0);
    check("ctrl_setup_u2", 64'(g_u[2].ctrl_bad), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
